instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: assembles 3-bit pad beats into 9-bit instructions and buffers
// them in a small circular FIFO that feeds the cpu one word per cycle.
//
// Ports:
//   CLK         - single clock, rising edge
//   RESET       - asynchronous, active-low reset
//   DIN         - 3-bit beat data from the pad interface
//   DIN_VALID   - DIN carries a beat this cycle
//   SYNC        - with DIN_VALID, marks the first beat of an instruction
//   CPU_READY   - cpu accepts an instruction this cycle
//   INSTRUCTION - registered instruction word presented to the cpu
//   write_en    - registered one-cycle strobe, INSTRUCTION is new
//   LEVEL       - FIFO occupancy, 0..DEPTH
//   FULL/EMPTY  - occupancy flags
//   OVERFLOW    - sticky, a completed word was dropped on a full FIFO
//   SYNC_ERR    - sticky, SYNC arrived while a partial word was pending
module instr_loader #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [2:0]               DIN,
    input  logic                     DIN_VALID,
    input  logic                     SYNC,
    input  logic                     CPU_READY,
    output logic [8:0]               INSTRUCTION,
    output logic                     write_en,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     OVERFLOW,
    output logic                     SYNC_ERR
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        BEAT0 = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } beat_e;

    beat_e       beat_q, beat_d;
    logic [8:0]  partial_q, partial_d;
    logic        push;
    logic [8:0]  push_word;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]  mem_q [DEPTH];

    logic [8:0]  instruction_q, instruction_d;
    logic        write_en_q, write_en_d;
    logic        overflow_q, overflow_d;
    logic        sync_err_q, sync_err_d;

    logic        fifo_full, fifo_empty;
    logic        pop, push_ok;

    // ------------------------------------------------------------------
    // Beat assembler: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            beat_q    <= BEAT0;
            partial_q <= '0;
        end else begin
            beat_q    <= beat_d;
            partial_q <= partial_d;
        end
    end

    // Beat assembler: next state. SYNC restarts the word from any count;
    // without SYNC the count is free-running.
    always_comb begin
        beat_d     = beat_q;
        partial_d  = partial_q;
        push       = 1'b0;
        push_word  = '0;
        sync_err_d = sync_err_q;
        if (DIN_VALID) begin
            if (SYNC) begin
                partial_d = {DIN, 6'b000000};
                beat_d    = BEAT1;
                if (beat_q != BEAT0) begin
                    sync_err_d = 1'b1;
                end
            end else begin
                unique case (beat_q)
                    BEAT0: begin
                        partial_d = {DIN, 6'b000000};
                        beat_d    = BEAT1;
                    end
                    BEAT1: begin
                        partial_d = {partial_q[8:6], DIN, 3'b000};
                        beat_d    = BEAT2;
                    end
                    BEAT2: begin
                        push      = 1'b1;
                        push_word = {partial_q[8:3], DIN};
                        partial_d = '0;
                        beat_d    = BEAT0;
                    end
                    default: begin
                        partial_d = '0;
                        beat_d    = BEAT0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop     = !fifo_empty && CPU_READY;
    // On a full FIFO the concurrent pop frees the head slot, so the write
    // lands in the entry being read out on this same edge.
    assign push_ok = push && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        instruction_d = instruction_q;
        write_en_d    = 1'b0;
        overflow_d    = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else if (push) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + PTR_ONE;
            instruction_d = mem_q[rd_ptr_q[AW-1:0]];
            write_en_d    = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            instruction_q <= '0;
            write_en_q    <= 1'b0;
            overflow_q    <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instruction_q <= instruction_d;
            write_en_q    <= write_en_d;
            overflow_q    <= overflow_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // Storage is not reset; pointers guarantee stale entries are never read.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_word;
        end
    end

    assign INSTRUCTION = instruction_q;
    assign write_en    = write_en_q;
    assign LEVEL       = wr_ptr_q - rd_ptr_q;
    assign FULL        = fifo_full;
    assign EMPTY       = fifo_empty;
    assign OVERFLOW    = overflow_q;
    assign SYNC_ERR    = sync_err_q;

endmodule
